// File: rtl/fp_alu_pkg.sv
// Shared definitions for the floating-point ALU I/O blocks: exception flag layout,
// outbound frame constants, and the result transmitter FSM state type.
package fp_alu_pkg;

  localparam int FLAG_W  = 5;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Upper three bits of every frame header; the host resynchronizes on this pattern.
  localparam logic [2:0] FRAME_HDR_SYNC = 3'b101;
  localparam int         FRAME_BYTES    = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RELEASE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/fp_result_tx_if.sv
// Result handshake between the ALU datapath (master) and the result transmitter (slave).
//   res_valid : result available (master)
//   res_ready : transmitter can accept (slave)
//   res_data  : IEEE-754 single result (master)
//   res_flags : {NV, DZ, OF, UF, NX} (master)
interface fp_result_tx_if;
  import fp_alu_pkg::*;

  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [FLAG_W-1:0] res_flags;

  modport master (output res_valid, output res_data, output res_flags, input res_ready);
  modport slave  (input res_valid, input res_data, input res_flags, output res_ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, both flops reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fp_result_tx.sv
// Byte-serial result transmitter. Captures one FP result plus flags and sends a
// 5-byte frame (header {101, NV, DZ, OF, UF, NX}, then data MSB first) to the host
// using a 4-phase strobe/acknowledge handshake, aborting on a stalled host.
//   clk, rst_n : clock, asynchronous active-low reset
//   res        : result handshake (slave side)
//   host_ack   : host acknowledge, asynchronous to clk
//   tx_data    : frame byte
//   tx_stb     : byte-valid strobe
//   tx_last    : high with the final byte of a frame
//   busy       : frame in progress
//   timeout    : one-cycle pulse when a frame is aborted
module fp_result_tx
  import fp_alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_result_tx_if.slave  res,
  input  logic           host_ack,
  output logic [7:0]     tx_data,
  output logic           tx_stb,
  output logic           tx_last,
  output logic           busy,
  output logic           timeout
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       LAST_IDX = 3'(FRAME_BYTES - 1);

  tx_state_e        state, state_n;
  logic [2:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt;
  logic [39:0]      hold;
  logic             ack_s;
  logic             ready_i;
  logic             accept;
  logic             abort;
  logic [7:0]       next_byte;

  function automatic logic [7:0] frame_byte(input logic [39:0] f, input logic [2:0] i);
    case (i)
      3'd0:    frame_byte = f[39:32];
      3'd1:    frame_byte = f[31:24];
      3'd2:    frame_byte = f[23:16];
      3'd3:    frame_byte = f[15:8];
      default: frame_byte = f[7:0];
    endcase
  endfunction

  sync_2ff u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (host_ack),
    .q     (ack_s)
  );

  // A new frame never starts while the host still holds ack from the last one.
  assign ready_i       = (state == ST_IDLE) && !ack_s;
  assign res.res_ready = ready_i;
  assign accept        = res.res_valid && ready_i;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    abort   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_PRESENT;
          idx_n   = 3'd0;
        end
      end
      ST_PRESENT: begin
        // An ack on the limit cycle wins over the timeout.
        if (ack_s) begin
          state_n = ST_RELEASE;
        end else if (cnt == CNT_LIM) begin
          state_n = ST_IDLE;
          abort   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          if (idx == LAST_IDX) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_PRESENT;
            idx_n   = idx + 3'd1;
          end
        end else if (cnt == CNT_LIM) begin
          state_n = ST_IDLE;
          abort   = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // The header comes straight from the inputs because hold is loaded on the same edge.
    next_byte = accept ? {FRAME_HDR_SYNC, res.res_flags} : frame_byte(hold, idx_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= 3'd0;
      cnt     <= '0;
      tx_data <= 8'd0;
      tx_stb  <= 1'b0;
      tx_last <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      // Counts cycles spent in the current wait state; restarts on each state entry.
      cnt     <= (state_n != state || state_n == ST_IDLE) ? '0 : cnt + CNT_W'(1);
      tx_stb  <= (state_n == ST_PRESENT);
      tx_last <= (state_n == ST_PRESENT) && (idx_n == LAST_IDX);
      busy    <= (state_n != ST_IDLE);
      timeout <= abort;
      // tx_data only changes when a new byte is presented, so it holds through RELEASE.
      if (state_n == ST_PRESENT && state != ST_PRESENT) begin
        tx_data <= next_byte;
      end
    end
  end

  // Holding register: plain data, loaded at acceptance only.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold <= {FRAME_HDR_SYNC, res.res_flags, res.res_data};
    end
  end

endmodule
